// File: rtl/knn_sorted_list.sv
// knn_sorted_list: keeps the K nearest candidates in a sorted list (slot 0
// nearest), inserting one candidate per cycle, and streams the list out on
// request through a valid/ready handshake.
module knn_sorted_list #(
  parameter int DATA_W  = 32,
  parameter int ID_W    = 8,
  parameter int NBR_KNN = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            dist_in,
  input  logic [ID_W-1:0]              id_in,
  input  logic                         rd_start,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_dist,
  output logic [ID_W-1:0]              out_id,
  output logic [$clog2(NBR_KNN):0]     out_rank,
  output logic                         out_last,
  output logic [$clog2(NBR_KNN):0]     count,
  output logic                         rd_done
);

  localparam int CW = $clog2(NBR_KNN) + 1;
  localparam logic [CW-1:0] K_CNT = CW'(NBR_KNN);

  typedef enum logic {ACCUM, READOUT} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       rank_q, rank_d;
  logic                rd_done_q, rd_done_d;
  logic [NBR_KNN-1:0]  occ_q, occ_d;
  logic [DATA_W-1:0]   dist_q [NBR_KNN];
  logic [DATA_W-1:0]   dist_d [NBR_KNN];
  logic [ID_W-1:0]     id_q   [NBR_KNN];
  logic [ID_W-1:0]     id_d   [NBR_KNN];

  logic                accept;
  logic [NBR_KNN-1:0]  base_occ;
  logic [CW-1:0]       base_cnt;
  logic [NBR_KNN-1:0]  gt;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == READOUT);
  assign out_rank  = rank_q;
  assign out_last  = (state_q == READOUT) && (rank_q == count_q - CW'(1));
  assign count     = count_q;
  assign rd_done   = rd_done_q;
  assign accept    = in_valid && in_ready;

  // Sorted insertion: gt marks slots the candidate belongs in front of. Because
  // the occupied prefix is sorted and empty slots trail it, gt is monotonic, so
  // the first set bit takes the candidate and later set bits shift down by one.
  // A candidate with no set bit (full list, dist_in >= last) is dropped.
  always_comb begin
    base_occ = clear ? '0 : occ_q;
    base_cnt = clear ? '0 : count_q;
    for (int i = 0; i < NBR_KNN; i++) begin
      gt[i]     = !base_occ[i] || (dist_q[i] > dist_in);
      dist_d[i] = dist_q[i];
      id_d[i]   = id_q[i];
    end
    occ_d   = base_occ;
    count_d = base_cnt;
    if (accept) begin
      if (base_cnt != K_CNT) count_d = base_cnt + CW'(1);
      if (gt[0]) begin
        dist_d[0] = dist_in;
        id_d[0]   = id_in;
        occ_d[0]  = 1'b1;
      end
      for (int i = 1; i < NBR_KNN; i++) begin
        if (gt[i] && !gt[i-1]) begin
          dist_d[i] = dist_in;
          id_d[i]   = id_in;
          occ_d[i]  = 1'b1;
        end else if (gt[i]) begin
          dist_d[i] = dist_q[i-1];
          id_d[i]   = id_q[i-1];
          occ_d[i]  = base_occ[i-1];
        end
      end
    end
  end

  // Accumulate/readout control: readout start sees the post-insert count, so a
  // candidate accepted alongside rd_start is part of the readout.
  always_comb begin
    state_d   = state_q;
    rank_d    = rank_q;
    rd_done_d = 1'b0;
    case (state_q)
      ACCUM: begin
        if (rd_start) begin
          if (count_d != '0) begin
            state_d = READOUT;
            rank_d  = '0;
          end else begin
            rd_done_d = 1'b1;
          end
        end
      end
      READOUT: begin
        if (clear) begin
          state_d = ACCUM;
          rank_d  = '0;
        end else if (out_ready) begin
          if (out_last) begin
            state_d   = ACCUM;
            rank_d    = '0;
            rd_done_d = 1'b1;
          end else begin
            rank_d = rank_q + CW'(1);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Output entry selection; zero outside readout.
  always_comb begin
    out_dist = '0;
    out_id   = '0;
    if (state_q == READOUT) begin
      for (int i = 0; i < NBR_KNN; i++) begin
        if (rank_q == CW'(i)) begin
          out_dist = dist_q[i];
          out_id   = id_q[i];
        end
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      count_q   <= '0;
      rank_q    <= '0;
      rd_done_q <= 1'b0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rank_q    <= rank_d;
      rd_done_q <= rd_done_d;
      occ_q     <= occ_d;
    end
  end

  // Slot payload; meaning is carried by occ_q, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBR_KNN; i++) begin
      dist_q[i] <= dist_d[i];
      id_q[i]   <= id_d[i];
    end
  end

endmodule

// File: tb/tb_knn_sorted_list.sv
// Directed bench for knn_sorted_list (K = 4): a reference list model feeds a
// scoreboard of expected readout entries that is drained as the DUT streams.
module tb_knn_sorted_list;

  localparam int DW = 32;
  localparam int IW = 8;
  localparam int K  = 4;
  localparam int CW = $clog2(K) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dist_in = '0;
  logic [IW-1:0] id_in = '0;
  logic          rd_start = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_dist;
  logic [IW-1:0] out_id;
  logic [CW-1:0] out_rank;
  logic          out_last;
  logic [CW-1:0] count;
  logic          rd_done;

  knn_sorted_list #(.DATA_W(DW), .ID_W(IW), .NBR_KNN(K)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .dist_in(dist_in), .id_in(id_in), .rd_start(rd_start), .out_valid(out_valid),
    .out_ready(out_ready), .out_dist(out_dist), .out_id(out_id), .out_rank(out_rank),
    .out_last(out_last), .count(count), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    int            rank;
    bit            last;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] md[$];
  logic [IW-1:0] mi[$];
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_rd_done"},   rd_done,   0);
    chk({tag, "_out_rank"},  out_rank,  0);
    chk({tag, "_out_dist"},  out_dist,  0);
    chk({tag, "_out_id"},    out_id,    0);
    chk({tag, "_count"},     count,     0);
  endtask

  task automatic model_insert(input logic [DW-1:0] d, input logic [IW-1:0] id);
    int p;
    p = md.size();
    for (int i = 0; i < md.size(); i++) begin
      if (md[i] > d) begin
        p = i;
        break;
      end
    end
    if (p < K) begin
      md.insert(p, d);
      mi.insert(p, id);
      if (md.size() > K) begin
        void'(md.pop_back());
        void'(mi.pop_back());
      end
    end
  endtask

  task automatic insert(input logic [DW-1:0] d, input logic [IW-1:0] id, input bit clr);
    chk("ins_ready", in_ready, 1);
    in_valid = 1'b1;
    dist_in  = d;
    id_in    = id;
    clear    = clr;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    if (clr) begin
      md.delete();
      mi.delete();
    end
    model_insert(d, id);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    md.delete();
    mi.delete();
    chk("clear_count", count, 0);
  endtask

  // abort_kind: 1 = clear, 2 = rst, applied when abort_rank is on the output
  task automatic readout(input int hold_rank, input int hold_n,
                         input int abort_rank, input int abort_kind);
    int            budget;
    exp_t          e;
    logic [DW-1:0] sd;
    logic [IW-1:0] si;
    logic [CW-1:0] sr;
    chk("count_pre", count, md.size());
    for (int i = 0; i < md.size(); i++)
      sb.push_back('{md[i], mi[i], i, (i == md.size() - 1)});
    rd_start  = 1'b1;
    out_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    if (md.size() == 0) begin
      chk("empty_rd_done", rd_done, 1);
      chk("empty_out_valid", out_valid, 0);
      chk("empty_in_ready", in_ready, 1);
      tick();
      chk("empty_rd_done_off", rd_done, 0);
      return;
    end
    budget = 40;
    while (sb.size() > 0 && budget > 0) begin
      budget--;
      if (out_valid) begin
        e = sb[0];
        chk("rd_dist", out_dist, e.d);
        chk("rd_id", out_id, e.id);
        chk("rd_rank", out_rank, e.rank);
        chk("rd_last", out_last, e.last);
        chk("rd_in_ready", in_ready, 0);
        if (e.rank == abort_rank) begin
          out_ready = 1'b0;
          if (abort_kind == 1) clear = 1'b1;
          else rst = 1'b1;
          tick();
          clear = 1'b0;
          rst   = 1'b0;
          sb.delete();
          md.delete();
          mi.delete();
          chk_idle("abort");
          tick();
          chk("abort_no_done", rd_done, 0);
          return;
        end
        if (e.rank == hold_rank && hold_n > 0) begin
          out_ready = 1'b0;
          sd = out_dist;
          si = out_id;
          sr = out_rank;
          repeat (hold_n) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_dist", out_dist, sd);
            chk("hold_id", out_id, si);
            chk("hold_rank", out_rank, sr);
            chk("hold_in_ready", in_ready, 0);
          end
          out_ready = 1'b1;
        end
        void'(sb.pop_front());
      end
      tick();
    end
    chk("sb_drained", sb.size(), 0);
    chk("rd_done", rd_done, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    tick();
    chk("rd_done_off", rd_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk_idle("in_reset");
    rst = 1'b0;
    tick();
    chk_idle("after_reset");

    // basic sort, backpressure at rank 1, then a repeat readout
    insert(50, 1, 0);
    insert(20, 2, 0);
    insert(80, 3, 0);
    insert(10, 4, 0);
    insert(30, 5, 0);
    chk("basic_count", count, 4);
    readout(1, 5, -1, 0);
    readout(-1, 0, -1, 0);

    // stable ties
    do_clear();
    insert(7, 1, 0);
    insert(7, 2, 0);
    insert(7, 3, 0);
    chk("tie_count", count, 3);
    readout(-1, 0, -1, 0);

    // full-list drops, then a new nearest
    do_clear();
    insert(1, 11, 0);
    insert(2, 12, 0);
    insert(3, 13, 0);
    insert(4, 14, 0);
    insert(4, 15, 0);
    insert(9, 16, 0);
    chk("full_count", count, 4);
    readout(-1, 0, -1, 0);
    insert(0, 17, 0);
    chk("full_count2", count, 4);
    readout(-1, 0, -1, 0);

    // clear aborts readout at rank 2, then empty readout
    readout(-1, 0, 2, 1);
    readout(-1, 0, -1, 0);

    // clear together with a candidate
    insert(40, 21, 0);
    insert(60, 22, 0);
    insert(55, 23, 1);
    chk("clr_ins_count", count, 1);
    readout(-1, 0, -1, 0);

    // reset mid-insert stream
    insert(5, 31, 0);
    insert(3, 32, 0);
    in_valid = 1'b1;
    dist_in  = 1;
    id_in    = 33;
    rst      = 1'b1;
    tick();
    in_valid = 1'b0;
    rst      = 1'b0;
    md.delete();
    mi.delete();
    chk_idle("rst_ins");

    // reset mid-readout
    insert(8, 41, 0);
    insert(6, 42, 0);
    insert(9, 43, 0);
    readout(-1, 0, 1, 2);

    // all-ones distance is a real entry
    insert({DW{1'b1}}, 77, 0);
    chk("ones_count", count, 1);
    readout(-1, 0, -1, 0);
    insert({DW{1'b1}}, 78, 0);
    insert(100, 79, 0);
    readout(-1, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
